store_merge_rmw: RTL and testbench



---
 rtl/store_merge_rmw.sv | 207 ++++++++++++++++++++
 tb/tb_store_merge_rmw.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge_rmw
//  Description : Sequential read-modify-write store unit. Word-aligns one
//                store request at a time, reads the memory word for sub-word
//                stores, merges the new byte lanes and writes the word back.
//                Optional one-entry store forwarding buffer enabled by the
//                STORE_FWD_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_merge_rmw #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_size,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              misalign_err,
    output logic              busy,
    input  logic              fwd_flush
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [2:0] c_max_size = 3'(OFF_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_wait_cnt;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_size;
    logic [OFF_W-1:0]  r_off;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic [3:0]        w_szmask;
    logic              w_reject;
    logic              w_full;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_word;
    logic [ADDR_W-1:0] w_aligned;

    // Replace lanes off..off+2^size-1 of base with the low bytes of data.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] data,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        size
    );
        logic [DATA_W-1:0] res;
        int                o;
        int                n;
        res = base;
        o   = int'(off);
        n   = 1 << size;
        for (int j = 0; j < NB; j++) begin
            if ((j < n) && ((o + j) < NB)) begin
                res[(o + j)*8 +: 8] = data[j*8 +: 8];
            end
        end
        return res;
    endfunction

    assign w_accept  = (r_state == S_IDLE) && st_valid;
    assign w_szmask  = (4'd1 << st_size) - 4'd1;
    assign w_reject  = ({1'b0, st_size} > c_max_size) ||
                       (|(w_szmask[OFF_W-1:0] & st_addr[OFF_W-1:0]));
    assign w_full    = ({1'b0, st_size} == c_max_size);
    assign w_aligned = {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef STORE_FWD_EN
    logic              r_fwd_valid;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [DATA_W-1:0] r_fwd_data;

    // Forwarding entry tracks the last written word; a flush overrides a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else begin
            if (r_state == S_WRITE) begin
                r_fwd_valid <= 1'b1;
                r_fwd_addr  <= r_addr;
                r_fwd_data  <= r_wdata;
            end
            if (fwd_flush) begin
                r_fwd_valid <= 1'b0;
            end
        end
    end

    assign w_fwd_hit  = r_fwd_valid && (r_fwd_addr == w_aligned);
    assign w_fwd_word = r_fwd_data;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = fwd_flush;
    assign w_fwd_hit    = 1'b0;
    assign w_fwd_word   = '0;
`endif

    // State register and read-latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_READ) begin
                r_wait_cnt <= 3'(RD_LAT);
            end else if ((r_state == S_WAIT) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_next       = r_state;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        misalign_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (st_valid) begin
                    if (w_reject) begin
                        w_next = S_ERR;
                    end else if (w_full || w_fwd_hit) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 3'd1) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_wr_en = 1'b1;
                w_next    = S_IDLE;
            end
            S_ERR: begin
                misalign_err = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request capture and merged write-word formation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_size  <= 2'd0;
            r_off   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept && !w_reject) begin
                r_data <= st_data;
                r_size <= st_size;
                r_off  <= st_addr[OFF_W-1:0];
                r_addr <= w_aligned;
                if (w_full) begin
                    r_wdata <= st_data;
                end else if (w_fwd_hit) begin
                    r_wdata <= merge_lanes(w_fwd_word, st_data, st_addr[OFF_W-1:0], st_size);
                end
            end else if ((r_state == S_WAIT) && (r_wait_cnt == 3'd1)) begin
                r_wdata <= merge_lanes(mem_rdata, r_data, r_off, r_size);
            end
        end
    end

    assign st_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_store_merge_rmw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_merge_rmw
//  Description : Self-checking bench for store_merge_rmw (DATA_W=32, RD_LAT=3)
//                with a byte-addressed reference memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_merge_rmw;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic [1:0]    st_size;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic          misalign_err;
    logic          busy;
    logic          fwd_flush;

    int total = 0;
    int bad   = 0;

    store_merge_rmw #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_size      (st_size),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .misalign_err (misalign_err),
        .busy         (busy),
        .fwd_flush    (fwd_flush)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT (word array) and reference memory (byte array).
    logic [31:0] mem_words [logic [31:0]];
    logic [7:0]  ref_bytes [logic [31:0]];
    int          cyc   = 0;
    int          rd_at = -100;
    logic [31:0] rd_addr = 0;

    bit          fwd_v = 0;
    logic [31:0] fwd_a = 0;
    logic [31:0] last_wdata;
    int          last_rd_n;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_words.exists(a)) return mem_words[a];
        return init_word(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_bytes.exists(a)) return ref_bytes[a];
        w = init_word(a & ~32'd3);
        return w[8*(a%4) +: 8];
    endfunction

    always @(posedge clk) cyc++;

    // Synchronous-read memory responder; data is garbage except in the valid cycle.
    always @(negedge clk) begin
        if (mem_wr_en) mem_words[mem_addr] = mem_wdata;
        if (mem_rd_en) begin
            rd_at   = cyc;
            rd_addr = mem_addr;
        end
        if (cyc == rd_at + RL) mem_rdata = mem_word(rd_addr);
        else                   mem_rdata = $urandom;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        logic [31:0] al;
        al = a & ~32'd3;
        mem_words[al] = w;
        for (int k = 0; k < 4; k++) ref_bytes[al + k] = w[8*k +: 8];
    endtask

    task automatic flush();
        @(negedge clk);
        fwd_flush = 1'b1;
        @(negedge clk);
        fwd_flush = 1'b0;
        fwd_v = 0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int nb, rd_n, rd_c, wr_c, er_c, both, exp_wr_c;
        bit err, full, hit, exp_rd;
        logic [31:0] al, exp_w, wa, wd;
        nb   = 1 << sz;
        err  = (nb > 4) || ((a % nb) != 0);
        al   = a & ~32'd3;
        full = !err && (nb == 4);
        hit  = 0;
`ifdef STORE_FWD_EN
        hit  = !err && !full && fwd_v && (fwd_a == al);
`endif
        exp_rd   = !err && !full && !hit;
        exp_wr_c = err ? 0 : (exp_rd ? 2 + RL : 1);
        exp_w    = 0;
        if (!err) begin
            for (int j = 0; j < nb; j++) ref_bytes[a + j] = d[8*j +: 8];
            for (int k = 0; k < 4; k++) exp_w[8*k +: 8] = ref_byte(al + k);
        end
        @(negedge clk);
        check("ready_before", st_ready, 1);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_data  = $urandom;
        rd_n = 0; rd_c = 0; wr_c = 0; er_c = 0; both = 0; wa = 0; wd = 0;
        for (int k = 1; k <= 20; k++) begin
            if (mem_rd_en) begin rd_n++; rd_c = k; end
            if (mem_rd_en && mem_wr_en) both++;
            if (mem_wr_en) begin wr_c = k; wa = mem_addr; wd = mem_wdata; end
            if (misalign_err) er_c = k;
            if (wr_c != 0 || er_c != 0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("rd_count", rd_n, exp_rd ? 1 : 0);
        check("rd_cycle", rd_c, exp_rd ? 1 : 0);
        check("wr_cycle", wr_c, exp_wr_c);
        check("err_cycle", er_c, err ? 1 : 0);
        check("rd_wr_overlap", both, 0);
        if (!err) begin
            check("wr_addr", wa, al);
            check("wr_data", wd, exp_w);
            fwd_v = 1;
            fwd_a = al;
        end
        check("ready_after", st_ready, 1);
        check("busy_after", busy, 0);
        last_wdata = wd;
        last_rd_n  = rd_n;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_seen;
        logic [31:0] ra, rdat;
        logic [1:0]  rsz;
        rst_n = 1'b0; st_valid = 1'b0; st_addr = 0; st_data = 0; st_size = 0;
        fwd_flush = 1'b0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", st_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_err", misalign_err, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store, no read.
        do_store(32'h100, 32'hDEAD_BEEF, 2'd2);
        check("t1_wdata", last_wdata, 32'hDEAD_BEEF);

        // Byte store into top lane.
        flush();
        preload(32'h100, 32'h1122_3344);
        do_store(32'h103, 32'h0000_00AA, 2'd0);
        check("t2_wdata", last_wdata, 32'hAA22_3344);

        // Halfword store into upper half.
        flush();
        preload(32'h100, 32'h1122_3344);
        do_store(32'h102, 32'h0000_5566, 2'd1);
        check("t3_wdata", last_wdata, 32'h5566_3344);

        // Misaligned halfword and oversize request.
        do_store(32'h101, 32'h0000_1234, 2'd1);
        do_store(32'h108, 32'h0000_1234, 2'd3);

        // Reset asserted during WAIT aborts without a write.
        @(negedge clk);
        st_valid = 1'b1; st_addr = 32'h501; st_data = 32'h77; st_size = 2'd0;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t5_busy_wait", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_busy_rst", busy, 0);
        check("t5_ready_rst", st_ready, 1);
        check("t5_wr_rst", mem_wr_en, 0);
        wr_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (mem_wr_en) wr_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        fwd_v = 0;
        check("t5_no_write", wr_seen, 0);
        do_store(32'h500, 32'h0000_0099, 2'd0);

        // Word then byte to the same word, then again after a flush.
        flush();
        do_store(32'h200, 32'h1122_3344, 2'd2);
        do_store(32'h200, 32'h0000_00AA, 2'd0);
        check("t6_wdata", last_wdata, 32'h1122_33AA);
        flush();
        do_store(32'h200, 32'h0000_00BB, 2'd0);
        check("t6_flush_read", last_rd_n, 1);
        check("t6_flush_wdata", last_wdata, 32'h1122_33BB);

        // Randomized stores over a small window to exercise reuse.
        for (int i = 0; i < 40; i++) begin
            if (($urandom % 4) == 0) flush();
            ra   = 32'h400 + ($urandom % 48);
            rdat = $urandom;
            rsz  = 2'($urandom % 4);
            do_store(ra, rdat, rsz);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
